fetch_ctrl: RTL and testbench

- Program-counter sequencer for the synchronous 8-bit instruction ROM (`instr_mem`). The ROM has 1-cycle read latency and presents `instr`/`imm` for the address sampled at the previous edge.
- Issues ROM addresses, advances by instruction length (1 byte, or 2 when an immediate follows), handles decode backpressure, branch redirects and halt/resume.
- Delivers a valid/ready instruction stream to decode.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/instr_mem.sv | 26 ++
 rtl/fetch_ctrl.sv | 66 ++++++
 tb/tb_fetch_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction opcodes, fetch sequencer states and the
// instruction-length helper used by both fetch and decode.
package cpu_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [7:0] {
    NOP  = 8'h00,
    ADDI = 8'h01,
    LDI  = 8'h02,
    JMP  = 8'h03,
    ADD  = 8'h10,
    SUB  = 8'h11,
    WO   = 8'h20,
    HLT  = 8'h3F
  } e_instr;

  typedef enum logic [1:0] {BOOT, RUN, HALT} e_fetch_state;

  // The single list of opcodes that are followed by an immediate byte.
  function automatic logic [1:0] instr_len(e_instr op);
    case (op)
      ADDI, LDI, JMP: return 2'd2;
      default:        return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Synchronous instruction ROM with a load port; returns the opcode at addr and
// the following byte (immediate) one cycle after the address is sampled.
module instr_mem
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] addr,
  output e_instr     instr,
  output logic [7:0] imm
);

  logic [7:0] mem [256];
  logic [7:0] addr_nxt;

  assign addr_nxt = addr + 8'd1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    instr <= e_instr'(mem[addr]);
    imm   <= mem[addr_nxt];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer in front of instr_mem: issues ROM addresses,
// steps by instruction length, and handles stalls, redirects and halt/resume.
//
// state | meaning
// BOOT  | ROM read of fetch_pc in flight, nothing to present yet
// RUN   | ROM data for fetch_pc is on mem_instr and offered to decode
// HALT  | fetching stopped; ROM keeps re-reading fetch_pc
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              WORD     = 8,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [WORD-1:0] mem_addr,
  input  e_instr          mem_instr,
  input  logic [WORD-1:0] mem_imm,
  output e_instr          out_instr,
  output logic [WORD-1:0] out_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_pc,
  input  logic            br_taken,
  input  logic [WORD-1:0] br_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted
);

  e_fetch_state    state;
  logic [WORD-1:0] fetch_pc;
  logic [WORD-1:0] seq_pc;
  logic            xfer;

  assign seq_pc    = fetch_pc + WORD'(instr_len(mem_instr));
  assign out_pc    = fetch_pc;
  assign out_instr = mem_instr;
  assign out_imm   = mem_imm;

  always_comb begin
    out_valid = (state == RUN) && !br_taken;
    halted    = (state == HALT);
    xfer      = out_valid && out_ready;
    if ((state != BOOT) && br_taken) mem_addr = br_target;
    else if (xfer)                   mem_addr = seq_pc;
    else                             mem_addr = fetch_pc;
  end

  // fetch_pc always tracks the address the ROM sampled at this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      fetch_pc <= mem_addr;
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (xfer && halt_req) state <= HALT;
        HALT:    if (resume && !br_taken) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with real instr_mem: instance A (RESET_PC=0) is checked
// every cycle against a ROM-level model; instance B (RESET_PC=0xFF) checks wrap.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic       ready = 1'b1, br = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [7:0] br_tgt = '0;

  logic [7:0] a_addr, a_imm, a_out_imm, a_pc;
  e_instr     a_instr, a_out_instr;
  logic       a_valid, a_halted;

  logic [7:0] b_addr, b_imm, b_out_imm, b_pc;
  e_instr     b_instr, b_out_instr;
  logic       b_valid, b_halted;
  logic       one = 1'b1, zero = 1'b0;
  logic [7:0] zero8 = '0;

  instr_mem u_mem_a (.clk(clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                     .addr(a_addr), .instr(a_instr), .imm(a_imm));
  fetch_ctrl #(.WORD(8), .RESET_PC(8'h00)) u_dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_addr), .mem_instr(a_instr), .mem_imm(a_imm),
    .out_instr(a_out_instr), .out_imm(a_out_imm), .out_valid(a_valid), .out_ready(ready),
    .out_pc(a_pc), .br_taken(br), .br_target(br_tgt), .halt_req(halt_req),
    .resume(resume), .halted(a_halted));

  instr_mem u_mem_b (.clk(clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                     .addr(b_addr), .instr(b_instr), .imm(b_imm));
  fetch_ctrl #(.WORD(8), .RESET_PC(8'hFF)) u_dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_instr(b_instr), .mem_imm(b_imm),
    .out_instr(b_out_instr), .out_imm(b_out_imm), .out_valid(b_valid), .out_ready(one),
    .out_pc(b_pc), .br_taken(zero), .br_target(zero8), .halt_req(zero),
    .resume(zero), .halted(b_halted));

  int checks = 0;
  int errors = 0;
  logic [7:0] rom [256];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes that introduce an immediate: ADDI, LDI, JMP.
  function automatic int len_of(logic [7:0] op);
    return (op == 8'h01 || op == 8'h02 || op == 8'h03) ? 2 : 1;
  endfunction

  function automatic logic [7:0] rom_init(int a);
    case (a)
      1:       return 8'h01;
      2:       return 8'hFF;
      3:       return 8'h20;
      4:       return 8'h10;
      8'hFE:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Program-level model of instance A: which address is on offer, and whether
  // the fetcher is still starting up or parked.
  bit         m_boot = 1'b1, m_halt = 1'b0, seen2 = 1'b0;
  logic [7:0] m_pc = 8'h00;

  always @(negedge clk) begin
    logic [7:0] e_addr, nxt, ip;
    bit e_valid, e_halted;
    if (rst) begin
      chk("rst_valid", a_valid, 0);
      chk("rst_halted", a_halted, 0);
      chk("rst_addr", a_addr, 0);
      chk("rst_pc", a_pc, 0);
      m_boot = 1'b1; m_halt = 1'b0; m_pc = 8'h00;
    end else begin
      e_valid = 1'b0; e_halted = 1'b0; e_addr = m_pc; nxt = m_pc;
      if (m_boot) m_boot = 1'b0;
      else if (m_halt) begin
        e_halted = 1'b1;
        if (br) begin e_addr = br_tgt; nxt = br_tgt; end
        else if (resume) m_halt = 1'b0;
      end else if (br) begin
        e_addr = br_tgt; nxt = br_tgt;
      end else begin
        e_valid = 1'b1;
        if (ready) begin
          nxt = m_pc + 8'(len_of(rom[m_pc]));
          e_addr = nxt;
          if (halt_req) m_halt = 1'b1;
        end
      end
      chk("m_valid", a_valid, e_valid);
      chk("m_halted", a_halted, e_halted);
      chk("m_addr", a_addr, e_addr);
      if (e_valid) begin
        ip = m_pc + 8'd1;
        chk("m_pc", a_pc, m_pc);
        chk("m_instr", a_out_instr, rom[m_pc]);
        chk("m_imm", a_out_imm, rom[ip]);
      end
      if (a_valid && a_pc == 8'h02) seen2 = 1'b1;
      m_pc = nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tick();
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = rom_init(i); rom[i] = rom_init(i);
    end
    tick();
    wr_en = 1'b0;
    #1;
    chk("reset_a_addr", a_addr, 8'h00);
    chk("reset_b_addr", b_addr, 8'hFF);
    chk("reset_b_pc", b_pc, 8'hFF);
    chk("reset_b_valid", b_valid, 0);

    tick(); rst = 1'b0; #1;
    chk("boot_a_valid", a_valid, 0);
    chk("boot_b_valid", b_valid, 0);
    tick(); #1;
    chk("c2_pc", a_pc, 8'h00); chk("c2_valid", a_valid, 1); chk("c2_instr", a_out_instr, NOP);
    chk("wrap_b_pc0", b_pc, 8'hFF); chk("wrap_b_valid", b_valid, 1); chk("wrap_b_instr", b_out_instr, NOP);
    tick(); ready = 1'b0; #1;
    chk("stall1_pc", a_pc, 8'h01); chk("stall1_instr", a_out_instr, ADDI);
    chk("stall1_imm", a_out_imm, 8'hFF); chk("stall1_addr", a_addr, 8'h01);
    chk("wrap_b_pc1", b_pc, 8'h00);
    tick(); #1;
    chk("stall2_pc", a_pc, 8'h01); chk("stall2_valid", a_valid, 1); chk("stall2_addr", a_addr, 8'h01);
    chk("wrap_b_pc2", b_pc, 8'h01); chk("wrap_b_imm", b_out_imm, 8'hFF);
    tick(); #1;
    chk("stall3_pc", a_pc, 8'h01); chk("stall3_instr", a_out_instr, ADDI);
    chk("wrap_b_pc3", b_pc, 8'h03);
    tick(); ready = 1'b1; #1;
    chk("unstall_addr", a_addr, 8'h03); chk("unstall_pc", a_pc, 8'h01);
    tick(); br = 1'b1; br_tgt = 8'h00; #1;
    chk("br_valid", a_valid, 0); chk("br_addr", a_addr, 8'h00);
    tick(); br = 1'b0; #1;
    chk("br_next_pc", a_pc, 8'h00); chk("br_next_valid", a_valid, 1); chk("br_next_instr", a_out_instr, NOP);
    tick(); halt_req = 1'b1; #1;
    chk("halt_xfer_pc", a_pc, 8'h01); chk("halt_xfer_addr", a_addr, 8'h03);
    tick(); halt_req = 1'b0; #1;
    chk("halt_halted", a_halted, 1); chk("halt_valid", a_valid, 0); chk("halt_addr", a_addr, 8'h03);
    tick(); resume = 1'b1; #1;
    chk("resume_still_halted", a_halted, 1);
    tick(); resume = 1'b0; #1;
    chk("resume_pc", a_pc, 8'h03); chk("resume_valid", a_valid, 1);
    chk("resume_instr", a_out_instr, WO); chk("resume_halted", a_halted, 0);
    tick(); br = 1'b1; br_tgt = 8'hFE; #1;
    chk("br_fe_addr", a_addr, 8'hFE);
    tick(); br = 1'b0; #1;
    chk("fe_pc", a_pc, 8'hFE); chk("fe_instr", a_out_instr, ADDI); chk("fe_wrap_addr", a_addr, 8'h00);
    tick(); #1;
    chk("fe_wrap_pc", a_pc, 8'h00);
    tick(); halt_req = 1'b1; ready = 1'b0; #1;
    chk("hstall_pc", a_pc, 8'h01); chk("hstall_halted", a_halted, 0); chk("hstall_addr", a_addr, 8'h01);
    tick(); ready = 1'b1; #1;
    chk("hstall_xfer_addr", a_addr, 8'h03);
    tick(); halt_req = 1'b0; br = 1'b1; br_tgt = 8'h00; #1;
    chk("hbr_halted", a_halted, 1); chk("hbr_addr", a_addr, 8'h00);
    tick(); br = 1'b0; resume = 1'b1; #1;
    chk("hbr_hold_addr", a_addr, 8'h00);
    tick(); resume = 1'b0; #1;
    chk("hbr_resume_pc", a_pc, 8'h00); chk("hbr_resume_valid", a_valid, 1);
    tick(); tick(); #1;
    chk("pre_rst_pc", a_pc, 8'h03);
    rst = 1'b1; #1;
    chk("async_valid", a_valid, 0); chk("async_addr", a_addr, 8'h00);
    chk("async_pc", a_pc, 8'h00); chk("async_b_addr", b_addr, 8'hFF);
    tick(); tick(); rst = 1'b0; #1;
    chk("reboot_valid", a_valid, 0);
    tick(); #1;
    chk("reboot_pc", a_pc, 8'h00); chk("reboot_valid2", a_valid, 1);
    tick(); tick(); #1;
    chk("never_pc2", seen2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
